// File: rtl/c7bicu_ctl.sv
// c7bicu_ctl: IFU->ICU fetch responder that turns each accepted fetch into one AR/R read on the BIU.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   ifu_icu_req_ic1/addr_ic1          level fetch request and address from the IFU
//   icu_ifu_ack_ic1                   one-cycle accept pulse
//   icu_ifu_data_valid_ic2/data/err   one-cycle data-valid with held instruction word and bus error
//   icu_biu_ar*/biu_icu_arready       read address channel
//   icu_biu_rready/biu_icu_r*         read data channel
//   icu_inv                           invalidate the line buffer
// Optional: define C7BICU_LBUF_EN for a one-entry line buffer that serves repeat fetches without bus traffic.
module c7bicu_ctl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_icu_req_ic1,
  input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
  output logic              icu_ifu_ack_ic1,
  output logic              icu_ifu_data_valid_ic2,
  output logic [DATA_W-1:0] icu_ifu_data_ic2,
  output logic              icu_ifu_err_ic2,
  output logic              icu_biu_arvalid,
  output logic [ADDR_W-1:0] icu_biu_araddr,
  input  logic              biu_icu_arready,
  output logic              icu_biu_rready,
  input  logic              biu_icu_rvalid,
  input  logic [DATA_W-1:0] biu_icu_rdata,
  input  logic [1:0]        biu_icu_rresp,
  input  logic              icu_inv
);
  typedef enum logic [2:0] {IDLE, ACK, AR, R, RSP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic err_q, err_d;
  logic hit;
  logic [DATA_W-1:0] hit_data;
  logic capture;
  assign capture = state_q == R && biu_icu_rvalid;
`ifdef C7BICU_LBUF_EN
  logic lb_vld_q;
  logic [ADDR_W-3:0] lb_tag_q;
  logic [DATA_W-1:0] lb_data_q;
  assign hit = lb_vld_q && lb_tag_q == addr_q[ADDR_W-1:2];
  assign hit_data = lb_data_q;
  // Error captures invalidate instead of filling; inv wins over a same-cycle fill.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lb_vld_q  <= 1'b0;
      lb_tag_q  <= '0;
      lb_data_q <= '0;
    end else begin
      if (capture) lb_vld_q <= !biu_icu_rresp[1];
      if (capture && !biu_icu_rresp[1]) begin
        lb_tag_q  <= addr_q[ADDR_W-1:2];
        lb_data_q <= biu_icu_rdata;
      end
      if (icu_inv) lb_vld_q <= 1'b0;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = icu_inv;
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  logic unused_rresp;
  assign unused_rresp = biu_icu_rresp[0];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = ifu_icu_req_ic1 ? ACK : IDLE;
      ACK:  state_d = hit ? RSP : AR;
      AR:   state_d = biu_icu_arready ? R : AR;
      R:    state_d = biu_icu_rvalid ? RSP : R;
      default: state_d = IDLE;
    endcase
    addr_d = state_q == IDLE && ifu_icu_req_ic1 ? ifu_icu_addr_ic1 : addr_q;
    data_d = capture ? biu_icu_rdata : state_q == ACK && hit ? hit_data : data_q;
    err_d  = capture ? biu_icu_rresp[1] : state_q == ACK && hit ? 1'b0 : err_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  assign icu_ifu_ack_ic1        = state_q == ACK;
  assign icu_ifu_data_valid_ic2 = state_q == RSP;
  assign icu_ifu_data_ic2       = data_q;
  assign icu_ifu_err_ic2        = err_q;
  assign icu_biu_arvalid        = state_q == AR;
  assign icu_biu_araddr         = addr_q;
  assign icu_biu_rready         = state_q == R;
endmodule

// File: tb/tb_c7bicu_ctl.sv
// tb_c7bicu_ctl: directed and randomized fetches against a transaction-level model of c7bicu_ctl.
module tb_c7bicu_ctl;
`ifdef C7BICU_LBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic req = 1'b0, arready = 1'b0, rvalid = 1'b0, inv = 1'b0;
  logic [31:0] addr = '0, rdata = '0;
  logic [1:0] rresp = '0;
  logic ack, dv, err, arvalid, rready;
  logic [31:0] data, araddr;
  int nvec = 0, nerr = 0;
  logic lb_vld = 1'b0;
  logic [29:0] lb_tag = '0;
  logic [31:0] lb_data = '0;
  always #5 clk = ~clk;
  c7bicu_ctl dut (
    .clk(clk), .resetn(resetn),
    .ifu_icu_req_ic1(req), .ifu_icu_addr_ic1(addr),
    .icu_ifu_ack_ic1(ack), .icu_ifu_data_valid_ic2(dv),
    .icu_ifu_data_ic2(data), .icu_ifu_err_ic2(err),
    .icu_biu_arvalid(arvalid), .icu_biu_araddr(araddr), .biu_icu_arready(arready),
    .icu_biu_rready(rready), .biu_icu_rvalid(rvalid), .biu_icu_rdata(rdata),
    .biu_icu_rresp(rresp), .icu_inv(inv)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One fetch seen as a transaction: the BIU answers after ard/rd wait cycles, and the
  // model predicts latencies, beat counts and returned data from those delays alone.
  // pre: req is already pending from the previous fetch. pend: raise req for a2 during R.
  task automatic fetch(input logic [31:0] a, input int ard, input int rd, input logic [31:0] d,
                       input logic [1:0] rr, input bit pre, input bit pend, input logic [31:0] a2);
    int cyc, ack_cyc, dv_cyc, acks, dvs, arv, rrc, aw, rw;
    bit bad_ar, ps, hit;
    logic [31:0] ed, got_d;
    logic ee, got_e;
    cyc = 0; ack_cyc = -1; dv_cyc = -1; acks = 0; dvs = 0; arv = 0; rrc = 0; aw = 0; rw = 0;
    bad_ar = 0; ps = 0; got_d = 'x; got_e = 1'bx;
    hit = lb_vld && lb_tag == a[31:2];
    ed = hit ? lb_data : d;
    ee = hit ? 1'b0 : rr[1];
    if (!pre) begin
      req = 1'b1;
      addr = a;
    end
    while (dv_cyc < 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ack) begin
        acks++;
        if (ack_cyc < 0) ack_cyc = cyc;
        req = 1'b0;
        addr = $urandom;
      end
      arready = arvalid && aw == ard;
      if (arvalid) begin
        arv++;
        aw++;
        if (araddr !== a) bad_ar = 1;
      end
      rvalid = rready && rw == rd;
      rdata = rvalid ? d : $urandom;
      rresp = rvalid ? rr : 2'($urandom);
      if (rready) begin
        rrc++;
        rw++;
        if (pend && !ps) begin
          req = 1'b1;
          addr = a2;
          ps = 1;
        end
      end
      if (dv) begin
        dvs++;
        dv_cyc = cyc;
        got_d = data;
        got_e = err;
      end
    end
    if (!pend) repeat (2) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (dv) dvs++;
    end
    if (pre) chk("ack_gap_after_dv", 32'(ack_cyc >= 2), 1);
    else chk("ack_lat", ack_cyc, 1);
    chk("ack_to_dv", dv_cyc - ack_cyc, hit ? 1 : 3 + ard + rd);
    chk("arvalid_cycles", arv, hit ? 0 : ard + 1);
    chk("rready_cycles", rrc, hit ? 0 : rd + 1);
    chk("araddr_stable", 32'(bad_ar), 0);
    chk("data", got_d, ed);
    chk("err", 32'(got_e), 32'(ee));
    chk("ack_count", acks, 1);
    chk("dv_count", dvs, 1);
    if (LB && !hit) begin
      lb_vld = !rr[1];
      if (!rr[1]) begin
        lb_tag = a[31:2];
        lb_data = d;
      end
    end
  endtask
  task automatic inv_pulse();
    inv = 1'b1;
    @(posedge clk); #1;
    inv = 1'b0;
    lb_vld = 1'b0;
  endtask
  initial begin
    logic [31:0] a, prev;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {27'b0, ack, dv, err, arvalid, rready}, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_data", data, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    fetch(32'h1C000000, 0, 0, 32'h02800000, 2'b00, 0, 0, 0);
    fetch(32'h1C000010, 4, 3, $urandom, 2'b00, 0, 0, 0);
    fetch(32'h1C000020, 0, 1, $urandom, 2'b00, 0, 1, 32'h1C000040);
    fetch(32'h1C000040, 1, 0, $urandom, 2'b01, 1, 0, 0);
    fetch(32'h1C000080, 0, 0, 32'hDEADBEEF, 2'b10, 0, 0, 0);
    fetch(32'h1C000084, 0, 0, $urandom, 2'b00, 0, 0, 0);
    fetch(32'h1C000000, 0, 0, 32'h02800000, 2'b00, 0, 0, 0);
    fetch(32'h1C000000, 2, 1, 32'h02800000, 2'b00, 0, 0, 0);
    inv_pulse();
    fetch(32'h1C000000, 1, 1, 32'h02800000, 2'b00, 0, 0, 0);
    prev = 32'h1C000000;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 1) ? prev : {20'h1C000, 10'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) inv_pulse();
      fetch(a, $urandom_range(0, 4), $urandom_range(0, 4), $urandom, 2'($urandom), 0, 0, 0);
      prev = a;
    end
    req = 1'b1;
    addr = 32'h1C0000C0;
    @(posedge clk); #1;
    chk("rst_pre_ack", 32'(ack), 1);
    req = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_arvalid", 32'(arvalid), 1);
    #2 resetn = 1'b0;
    #1 chk("rst_async_drop", {28'b0, ack, dv, arvalid, rready}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    lb_vld = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_quiet", {28'b0, ack, dv, arvalid, rready}, 0);
    end
    fetch(32'h1C0000C0, 0, 2, $urandom, 2'b00, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
